// File: rtl/spike_detector_mc.sv
// rtl/spike_detector_mc.sv - multi-channel threshold spike detector with refractory and counters
//
// Purpose: compares every channel's signed sample against a shared signed
// threshold (positive, absolute or negative polarity), qualifies the crossing
// over MIN_ABOVE consecutive valid samples, then emits a one-cycle spike
// pulse. After a fire the channel ignores REFRACT valid samples and must see
// one below-threshold sample before it can re-arm. Each channel keeps a
// saturating spike counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   q carries a new sample for every channel
//   q          NCH packed signed samples, channel c = q[c*W +: W]
//   soglia     shared signed threshold
//   mode       0 pos, 1 abs, 2 neg, 3 same as pos
//   cnt_clr    clear all spike counters
//   spike      registered one-cycle spike pulse per channel
//   spike_any  registered OR of the spike flags
//   spike_cnt  NCH packed saturating counters, channel c = spike_cnt[c*CNT_W +: CNT_W]

module spike_detector_mc #(
  parameter int NCH       = 4,
  parameter int W         = 12,
  parameter int MIN_ABOVE = 1,
  parameter int REFRACT   = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NCH*W-1:0]     q,
  input  logic [W-1:0]         soglia,
  input  logic [1:0]           mode,
  input  logic                 cnt_clr,
  output logic [NCH-1:0]       spike,
  output logic                 spike_any,
  output logic [NCH*CNT_W-1:0] spike_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    REFR     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam int RUN_W = (MIN_ABOVE > 1) ? $clog2(MIN_ABOVE + 1) : 1;
  localparam int REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  // One extra bit so that |-2^(W-1)| and -soglia are representable.
  logic signed [W:0] thr;
  logic signed [W:0] thr_neg;
  assign thr     = {soglia[W-1], soglia};
  assign thr_neg = -thr;

  logic [NCH-1:0] fire;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [W:0]   s;
    logic signed [W:0]   s_abs;
    logic                above;
    logic                f;
    state_t              st;
    logic [RUN_W-1:0]    run;
    logic [REF_W-1:0]    rcnt;
    logic [CNT_W-1:0]    cnt;

    assign s     = {q[c*W+W-1], q[c*W +: W]};
    assign s_abs = s[W] ? -s : s;

    always_comb begin
      above = 1'b0;
      case (mode)
        2'd1:    above = (s_abs > thr);
        2'd2:    above = (s < thr_neg);
        default: above = (s > thr);
      endcase
    end

    // Fire on the sample that completes the run of MIN_ABOVE above samples.
    always_comb begin
      f = 1'b0;
      if (in_valid && above) begin
        if (st == IDLE && MIN_ABOVE == 1)
          f = 1'b1;
        else if (st == COUNT && (run + RUN_W'(1)) == RUN_W'(MIN_ABOVE))
          f = 1'b1;
      end
    end
    assign fire[c] = f;

    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= IDLE;
        run  <= '0;
        rcnt <= '0;
      end else if (in_valid) begin
        if (f) begin
          st   <= (REFRACT == 0) ? WAIT_LOW : REFR;
          rcnt <= REF_W'(REFRACT);
          run  <= '0;
        end else begin
          case (st)
            IDLE: begin
              if (above) begin
                st  <= COUNT;
                run <= RUN_W'(1);
              end
            end
            COUNT: begin
              if (above) begin
                run <= run + RUN_W'(1);
              end else begin
                st  <= IDLE;
                run <= '0;
              end
            end
            REFR: begin
              rcnt <= rcnt - REF_W'(1);
              if (rcnt <= REF_W'(1))
                st <= WAIT_LOW;
            end
            default: begin
              // The below sample that re-arms does not start a new run.
              if (!above)
                st <= IDLE;
            end
          endcase
        end
      end
    end

    // Clear wins over a simultaneous increment.
    always_ff @(posedge clk) begin
      if (rst || cnt_clr)
        cnt <= '0;
      else if (spike[c] && cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
    end
    assign spike_cnt[c*CNT_W +: CNT_W] = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike     <= '0;
      spike_any <= 1'b0;
    end else begin
      spike     <= fire;
      spike_any <= |fire;
    end
  end

endmodule

// File: tb/tb_spike_detector_mc.sv
// tb/tb_spike_detector_mc.sv - scoreboard bench for spike_detector_mc

module tb_spike_detector_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [47:0] q;
  logic [11:0] soglia;
  logic [1:0]  mode;
  logic        cnt_clr;
  logic [3:0]  spike_a, spike_b;
  logic        any_a, any_b;
  logic [7:0]  cnt_a;
  logic [31:0] cnt_b;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  localparam logic [47:0] Q24 = {4{12'd24}};
  localparam logic [11:0] H   = 12'h418;

  always #5 clk = ~clk;

  spike_detector_mc #(.NCH(4), .W(12), .MIN_ABOVE(1), .REFRACT(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .q(q), .soglia(soglia), .mode(mode),
    .cnt_clr(cnt_clr), .spike(spike_a), .spike_any(any_a), .spike_cnt(cnt_a)
  );

  spike_detector_mc #(.NCH(4), .W(12), .MIN_ABOVE(3), .REFRACT(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .q(q), .soglia(soglia), .mode(mode),
    .cnt_clr(cnt_clr), .spike(spike_b), .spike_any(any_b), .spike_cnt(cnt_b)
  );

  function automatic logic [47:0] mkq(input int c, input logic [11:0] v);
    logic [47:0] r;
    r = Q24;
    r[c*12 +: 12] = v;
    return r;
  endfunction

  // Push expected spikes {dut_a, dut_b}, apply one sample, land on the next negedge.
  task automatic drive(input logic v, input logic [47:0] qq, input logic [3:0] ea, input logic [3:0] eb);
    sb.push_back({ea, eb});
    in_valid = v;
    q        = qq;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; mode = 2'd0; q = Q24;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1; in_valid = 1'b1; q = {4{12'h7FF}}; mode = 2'd0; cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if ({spike_a, any_a, cnt_a, spike_b, any_b, cnt_b} !== '0) begin
        fails++;
        $display("FAIL reset[%0d] spike_a=%b cnt_a=%h spike_b=%b cnt_b=%h required all 0", i, spike_a, cnt_a, spike_b, cnt_b);
      end
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({spike_a, any_a, cnt_a, spike_b, any_b, cnt_b} !== '0) begin
      fails++;
      $display("FAIL reset_release spike_a=%b cnt_a=%h spike_b=%b cnt_b=%h required all 0", spike_a, cnt_a, spike_b, cnt_b);
    end
    drive(1'b1, {4{12'h7FF}}, 4'b1111, 4'b0000);
    e = sb.pop_front();
    tests++;
    if ({any_a, spike_a, any_b, spike_b} !== {|e[7:4], e[7:4], |e[3:0], e[3:0]}) begin
      fails++;
      $display("FAIL reset_first_fire got a=%b b=%b required a=%b b=%b", spike_a, spike_b, e[7:4], e[3:0]);
    end
  endtask

  task automatic test_single();
    logic [47:0] tq [12];
    logic [3:0]  ta [12];
    logic [3:0]  tb [12];
    logic [7:0]  e;
    do_reset();
    tq = '{Q24, mkq(0, H), Q24, mkq(0, H), mkq(0, H), mkq(0, H), mkq(0, H), mkq(0, H), mkq(0, H),
           Q24, mkq(0, H), Q24};
    ta = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tb = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tq[i], ta[i], tb[i]);
      e = sb.pop_front();
      tests++;
      if ({any_a, spike_a, any_b, spike_b} !== {|e[7:4], e[7:4], |e[3:0], e[3:0]}) begin
        fails++;
        $display("FAIL single[%0d] got a=%b/%b b=%b/%b required a=%b b=%b", i, spike_a, any_a, spike_b, any_b, e[7:4], e[3:0]);
      end
      if (i == 2) begin
        tests++;
        if (cnt_a !== 8'h01) begin
          fails++;
          $display("FAIL single_cnt1 cnt_a=%h required 01", cnt_a);
        end
      end
      if (i == 11) begin
        tests++;
        if (cnt_a !== 8'h02 || cnt_b !== 32'h1) begin
          fails++;
          $display("FAIL single_cnt2 cnt_a=%h cnt_b=%h required 02 and 1", cnt_a, cnt_b);
        end
      end
    end
  endtask

  task automatic test_min_above();
    logic [47:0] tq [7];
    logic        tv [7];
    logic [3:0]  ta [7];
    logic [3:0]  tb [7];
    logic [7:0]  e;
    do_reset();
    tq = '{mkq(1, H), mkq(1, H), Q24, mkq(1, H), mkq(1, H), mkq(1, H), mkq(1, H)};
    tv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ta = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tb = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
    for (int i = 0; i < 7; i++) begin
      drive(tv[i], tq[i], ta[i], tb[i]);
      e = sb.pop_front();
      tests++;
      if ({any_a, spike_a, any_b, spike_b} !== {|e[7:4], e[7:4], |e[3:0], e[3:0]}) begin
        fails++;
        $display("FAIL min_above[%0d] got a=%b b=%b required a=%b b=%b", i, spike_a, spike_b, e[7:4], e[3:0]);
      end
    end
  endtask

  task automatic test_modes();
    logic [47:0] tq [7];
    logic [1:0]  tm [7];
    logic [3:0]  ta [7];
    logic [7:0]  e;
    do_reset();
    tq = '{mkq(2, 12'h800), mkq(3, 12'hF00), mkq(3, 12'hEFF), mkq(0, 12'h800), mkq(0, 12'h101),
           mkq(1, 12'h100), mkq(1, 12'h101)};
    tm = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    ta = '{4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2};
    for (int i = 0; i < 7; i++) begin
      mode = tm[i];
      drive(1'b1, tq[i], ta[i], 4'h0);
      e = sb.pop_front();
      tests++;
      if ({any_a, spike_a, any_b, spike_b} !== {|e[7:4], e[7:4], |e[3:0], e[3:0]}) begin
        fails++;
        $display("FAIL modes[%0d] mode=%0d got a=%b b=%b required a=%b b=%b", i, tm[i], spike_a, spike_b, e[7:4], e[3:0]);
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [3];
    logic [3:0] tb [3];
    logic [7:0] e;
    do_reset();
    ta = '{4'hF, 4'h0, 4'h0};
    tb = '{4'h0, 4'h0, 4'hF};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {4{H}}, ta[i], tb[i]);
      e = sb.pop_front();
      tests++;
      if ({any_a, spike_a, any_b, spike_b} !== {|e[7:4], e[7:4], |e[3:0], e[3:0]}) begin
        fails++;
        $display("FAIL back_to_back[%0d] got a=%b b=%b required a=%b b=%b", i, spike_a, spike_b, e[7:4], e[3:0]);
      end
    end
  endtask

  task automatic test_cnt_sat();
    logic [47:0] p;
    logic [7:0]  e;
    p = {12'd24, 12'd24, H, H};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, p, 4'h3, 4'h0);
      for (int j = 0; j < 3; j++) drive(1'b1, Q24, 4'h0, 4'h0);
    end
    for (int k = 0; k < 16; k++) begin
      e = sb.pop_front();
      tests++;
      if (e[7:4] == 4'h3 && k % 4 != 0) begin
        fails++;
        $display("FAIL cnt_sb_order[%0d] required entry %h", k, e);
      end
    end
    tests++;
    if (cnt_a !== 8'h0F || cnt_b !== 32'h0) begin
      fails++;
      $display("FAIL cnt_saturate cnt_a=%h cnt_b=%h required 0f and 0", cnt_a, cnt_b);
    end
    drive(1'b1, p, 4'h3, 4'h0);
    e = sb.pop_front();
    tests++;
    if ({any_a, spike_a} !== {|e[7:4], e[7:4]}) begin
      fails++;
      $display("FAIL cnt_fifth_spike got a=%b required a=%b", spike_a, e[7:4]);
    end
    cnt_clr = 1'b1;
    drive(1'b1, Q24, 4'h0, 4'h0);
    cnt_clr = 1'b0;
    e = sb.pop_front();
    tests++;
    if (cnt_a !== 8'h00 || spike_a !== e[7:4]) begin
      fails++;
      $display("FAIL cnt_clear cnt_a=%h spike_a=%b required 00 and %b", cnt_a, spike_a, e[7:4]);
    end
    drive(1'b1, Q24, 4'h0, 4'h0);
    e = sb.pop_front();
    tests++;
    if (cnt_a !== 8'h00 || cnt_b !== 32'h0 || spike_a !== e[7:4]) begin
      fails++;
      $display("FAIL cnt_after_clear cnt_a=%h cnt_b=%h required 00 and 0", cnt_a, cnt_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; q = '0; soglia = 12'h100; mode = 2'd0; cnt_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_min_above();
    test_modes();
    test_back_to_back();
    test_cnt_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
